// File: rtl/cache_bus_burst.sv
// rtl/cache_bus_burst.sv - cache line fetch/writeback to one incrementing AHB-Lite burst
// Address phases of beat k overlap the data phase of beat k-1; LAST drains the final data phase.
module cache_bus_burst #(
    parameter int PA_BITS = 56,
    parameter int AHBW    = 64,
    parameter int LINELEN = 512
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           CacheBusRW,
    input  logic [PA_BITS-1:0]                   CacheBusAdr,
    input  logic                                 FlushStage,
    input  logic [AHBW-1:0]                      CacheReadData,
    output logic                                 CacheBusAck,
    output logic                                 CacheBusCommitted,
    output logic                                 SelBusBeat,
    output logic [$clog2(LINELEN/AHBW)-1:0]      BeatCount,
    output logic [LINELEN-1:0]                   FetchBuffer,
    output logic [PA_BITS-1:0]                   HADDR,
    output logic [1:0]                           HTRANS,
    output logic                                 HWRITE,
    output logic [2:0]                           HSIZE,
    output logic [2:0]                           HBURST,
    output logic [AHBW-1:0]                      HWDATA,
    input  logic [AHBW-1:0]                      HRDATA,
    input  logic                                 HREADY
);

    localparam int BEATSPERLINE = LINELEN / AHBW;
    localparam int LOGBWPL      = $clog2(BEATSPERLINE);
    localparam int OFFSETLEN    = $clog2(LINELEN / 8);
    localparam int BYTEBITS     = $clog2(AHBW / 8);
    localparam int LINEADRW     = PA_BITS - OFFSETLEN;

    localparam logic [LOGBWPL-1:0] LAST_BEAT = LOGBWPL'(BEATSPERLINE - 1);
    localparam logic [2:0] BURST_TYPE =
        (BEATSPERLINE == 1)  ? 3'b000 :
        (BEATSPERLINE == 4)  ? 3'b011 :
        (BEATSPERLINE == 8)  ? 3'b101 :
        (BEATSPERLINE == 16) ? 3'b111 : 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADR,
        S_LAST
    } state_t;

    state_t               state_q, state_d;
    logic [LINEADRW-1:0]  line_adr_q, line_adr_d;
    logic                 wr_q, wr_d;
    logic [LOGBWPL-1:0]   adr_beat_q, adr_beat_d;
    logic [LOGBWPL-1:0]   data_beat_q, data_beat_d;
    logic                 data_valid_q, data_valid_d;
    logic [AHBW-1:0]      hwdata_q, hwdata_d;
    logic [LINELEN-1:0]   fetch_buffer_q, fetch_buffer_d;
    logic                 ack;

    // Line offset bits of the request address are zero by contract.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, CacheBusAdr[OFFSETLEN-1:0]};

    always_comb begin
        state_d        = state_q;
        line_adr_d     = line_adr_q;
        wr_d           = wr_q;
        adr_beat_d     = adr_beat_q;
        data_beat_d    = data_beat_q;
        data_valid_d   = data_valid_q;
        hwdata_d       = hwdata_q;
        fetch_buffer_d = fetch_buffer_q;
        ack            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((CacheBusRW != 2'b00) && !FlushStage) begin
                    state_d    = S_ADR;
                    line_adr_d = CacheBusAdr[PA_BITS-1:OFFSETLEN];
                    wr_d       = CacheBusRW[0];
                    adr_beat_d = '0;
                end
            end
            S_ADR: begin
                if (HREADY) begin
                    data_beat_d  = adr_beat_q;
                    data_valid_d = 1'b1;
                    adr_beat_d   = adr_beat_q + LOGBWPL'(1);
                    if (wr_q) begin
                        hwdata_d = CacheReadData;
                    end
                    if (adr_beat_q == LAST_BEAT) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (HREADY) begin
                    ack          = 1'b1;
                    data_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read data completes whenever the bus is ready during an open data phase.
        if (data_valid_q && HREADY && !wr_q) begin
            fetch_buffer_d[data_beat_q*AHBW +: AHBW] = HRDATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            line_adr_q     <= '0;
            wr_q           <= 1'b0;
            adr_beat_q     <= '0;
            data_beat_q    <= '0;
            data_valid_q   <= 1'b0;
            hwdata_q       <= '0;
            fetch_buffer_q <= '0;
        end else begin
            state_q        <= state_d;
            line_adr_q     <= line_adr_d;
            wr_q           <= wr_d;
            adr_beat_q     <= adr_beat_d;
            data_beat_q    <= data_beat_d;
            data_valid_q   <= data_valid_d;
            hwdata_q       <= hwdata_d;
            fetch_buffer_q <= fetch_buffer_d;
        end
    end

    assign HADDR             = {line_adr_q, adr_beat_q, {BYTEBITS{1'b0}}};
    assign HTRANS            = (state_q != S_ADR)     ? 2'b00 :
                               (adr_beat_q == '0)     ? 2'b10 : 2'b11;
    assign HWRITE            = (state_q == S_ADR) & wr_q;
    assign HSIZE             = 3'(BYTEBITS);
    assign HBURST            = BURST_TYPE;
    assign HWDATA            = hwdata_q;
    assign FetchBuffer       = fetch_buffer_q;
    assign BeatCount         = adr_beat_q;
    assign CacheBusAck       = ack;
    assign CacheBusCommitted = (state_q != S_IDLE);
    assign SelBusBeat        = (state_q != S_IDLE) & wr_q;

endmodule
